// File: rtl/fsic_ls_cfg_bridge.sv
// Single-outstanding AXI-Lite window adapter onto the LS serdes config port.
// Optional downstream watchdog: define LS_CFG_TIMEOUT_EN.
module fsic_ls_cfg_bridge #(
    parameter int unsigned pUP_ADDR_WIDTH = 15,
    parameter int unsigned pADDR_WIDTH    = 10,
    parameter int unsigned pDATA_WIDTH    = 32,
    parameter int unsigned pLS_BASE       = 32'h5000,
    parameter int unsigned pLS_SIZE       = 4096,
    parameter int unsigned pTIMEOUT       = 255
) (
    input  logic                        axi_clk,
    input  logic                        axi_reset_n,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [pUP_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    input  logic [pDATA_WIDTH-1:0]      s_wdata,
    input  logic [pDATA_WIDTH/8-1:0]    s_wstrb,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    output logic [1:0]                  s_bresp,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    input  logic [pUP_ADDR_WIDTH-1:0]   s_araddr,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    output logic [pDATA_WIDTH-1:0]      s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [pADDR_WIDTH-1:0]      m_awaddr,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    output logic [pDATA_WIDTH-1:0]      m_wdata,
    output logic [pDATA_WIDTH/8-1:0]    m_wstrb,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    output logic [pADDR_WIDTH-1:0]      m_araddr,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    input  logic [pDATA_WIDTH-1:0]      m_rdata,
    output logic                        cc_ls_enable
);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [pUP_ADDR_WIDTH-1:0] LsBase = pUP_ADDR_WIDTH'(pLS_BASE);

    typedef enum logic [2:0] {
        StIdle, StWrIssue, StWrResp, StRdIssue, StRdWait, StRdResp
    } state_t;

    function automatic logic f_hit(input logic [pUP_ADDR_WIDTH-1:0] a);
        return (32'(a) >= pLS_BASE) && (32'(a) < pLS_BASE + pLS_SIZE);
    endfunction

    function automatic logic [pADDR_WIDTH-1:0] f_off(input logic [pUP_ADDR_WIDTH-1:0] a);
        return pADDR_WIDTH'((a - LsBase) >> 2);
    endfunction

    logic                       r_rst_done;
    logic                       r_aw_full, r_w_full, r_ar_full;
    logic [pUP_ADDR_WIDTH-1:0]  r_aw_addr, r_ar_addr;
    logic [pDATA_WIDTH-1:0]     r_w_data;
    logic [pDATA_WIDTH/8-1:0]   r_w_strb;
    state_t                     r_state, w_state_d;
    logic                       r_last_rd;
    logic                       r_m_wrvalid, r_m_arvalid, r_m_rready, r_cc_en;
    logic [pADDR_WIDTH-1:0]     r_m_awaddr, r_m_araddr;
    logic [pDATA_WIDTH-1:0]     r_m_wdata, r_s_rdata;
    logic [pDATA_WIDTH/8-1:0]   r_m_wstrb;
    logic                       r_s_bvalid, r_s_rvalid;
    logic [1:0]                 r_s_bresp, r_s_rresp;
    logic                       w_take_wr, w_take_rd, w_wr_hs, w_timeout;
    logic                       w_aw_hit, w_ar_hit;

    assign s_awready    = !r_aw_full && r_rst_done;
    assign s_wready     = !r_w_full && r_rst_done;
    assign s_arready    = !r_ar_full && r_rst_done;
    assign m_awvalid    = r_m_wrvalid;
    assign m_wvalid     = r_m_wrvalid;
    assign m_awaddr     = r_m_awaddr;
    assign m_wdata      = r_m_wdata;
    assign m_wstrb      = r_m_wstrb;
    assign m_arvalid    = r_m_arvalid;
    assign m_araddr     = r_m_araddr;
    assign m_rready     = r_m_rready;
    assign cc_ls_enable = r_cc_en;
    assign s_bvalid     = r_s_bvalid;
    assign s_bresp      = r_s_bresp;
    assign s_rvalid     = r_s_rvalid;
    assign s_rdata      = r_s_rdata;
    assign s_rresp      = r_s_rresp;

    assign w_aw_hit = f_hit(r_aw_addr);
    assign w_ar_hit = f_hit(r_ar_addr);
    assign w_wr_hs  = m_awready && m_wready;

`ifdef LS_CFG_TIMEOUT_EN
    logic [7:0] r_to_cnt;

    // Spans RD_ISSUE and RD_WAIT together: one budget per downstream access.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state == StIdle) begin
            r_to_cnt <= '0;
        end else if (r_state inside {StWrIssue, StRdIssue, StRdWait}) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_to_cnt == 8'(pTIMEOUT));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_take_wr = 1'b0;
        w_take_rd = 1'b0;
        w_state_d = r_state;
        if (r_state == StIdle) begin
            // On a tie, serve the opposite of what was served last.
            if (r_aw_full && r_w_full && (!r_ar_full || r_last_rd)) begin
                w_take_wr = 1'b1;
            end else if (r_ar_full) begin
                w_take_rd = 1'b1;
            end
        end
        unique case (r_state)
            StIdle: begin
                if (w_take_wr) w_state_d = w_aw_hit ? StWrIssue : StWrResp;
                else if (w_take_rd) w_state_d = w_ar_hit ? StRdIssue : StRdResp;
            end
            StWrIssue: if (w_wr_hs || w_timeout) w_state_d = StWrResp;
            StWrResp:  if (s_bready) w_state_d = StIdle;
            StRdIssue: begin
                if (m_arready) w_state_d = StRdWait;
                else if (w_timeout) w_state_d = StRdResp;
            end
            StRdWait:  if (m_rvalid || w_timeout) w_state_d = StRdResp;
            StRdResp:  if (s_rready) w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_rst_done <= 1'b0;
            r_aw_full  <= 1'b0;
            r_w_full   <= 1'b0;
            r_ar_full  <= 1'b0;
            r_aw_addr  <= '0;
            r_ar_addr  <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_take_wr) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end else begin
                if (s_awvalid && s_awready) begin
                    r_aw_full <= 1'b1;
                    r_aw_addr <= s_awaddr;
                end
                if (s_wvalid && s_wready) begin
                    r_w_full <= 1'b1;
                    r_w_data <= s_wdata;
                    r_w_strb <= s_wstrb;
                end
            end
            if (w_take_rd) begin
                r_ar_full <= 1'b0;
            end else if (s_arvalid && s_arready) begin
                r_ar_full <= 1'b1;
                r_ar_addr <= s_araddr;
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state     <= StIdle;
            r_last_rd   <= 1'b1;
            r_m_wrvalid <= 1'b0;
            r_m_arvalid <= 1'b0;
            r_m_rready  <= 1'b0;
            r_cc_en     <= 1'b0;
            r_s_bvalid  <= 1'b0;
            r_s_rvalid  <= 1'b0;
            r_m_awaddr  <= '0;
            r_m_araddr  <= '0;
            r_m_wdata   <= '0;
            r_m_wstrb   <= '0;
            r_s_bresp   <= RespOkay;
            r_s_rresp   <= RespOkay;
            r_s_rdata   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_m_wrvalid <= (w_state_d == StWrIssue);
            r_m_arvalid <= (w_state_d == StRdIssue);
            r_m_rready  <= (w_state_d == StRdWait);
            r_cc_en     <= (w_state_d inside {StWrIssue, StRdIssue, StRdWait});
            r_s_bvalid  <= (w_state_d == StWrResp);
            r_s_rvalid  <= (w_state_d == StRdResp);
            if (w_take_wr || w_take_rd) r_last_rd <= w_take_rd;
            if (w_take_wr) begin
                r_m_awaddr <= f_off(r_aw_addr);
                r_m_wdata  <= r_w_data;
                r_m_wstrb  <= r_w_strb;
                r_s_bresp  <= w_aw_hit ? RespOkay : RespSlvErr;
            end else if (r_state == StWrIssue && w_state_d == StWrResp) begin
                r_s_bresp <= w_wr_hs ? RespOkay : RespSlvErr;
            end
            if (w_take_rd) begin
                r_m_araddr <= f_off(r_ar_addr);
                if (!w_ar_hit) begin
                    r_s_rdata <= '0;
                    r_s_rresp <= RespSlvErr;
                end
            end else if (r_state inside {StRdIssue, StRdWait} && w_state_d == StRdResp) begin
                if (r_state == StRdWait && m_rvalid) begin
                    r_s_rdata <= m_rdata;
                    r_s_rresp <= RespOkay;
                end else begin
                    r_s_rdata <= '0;
                    r_s_rresp <= RespSlvErr;
                end
            end
        end
    end

endmodule

// File: tb/tb_fsic_ls_cfg_bridge.sv
// Self-checking bench for fsic_ls_cfg_bridge: directed timing scenarios plus randomized
// traffic against a window/memory reference model; honours LS_CFG_TIMEOUT_EN.
module tb_fsic_ls_cfg_bridge;
    localparam int unsigned BASE = 32'h5000;
    localparam int unsigned SIZE = 4096;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n = 1'b0;
    logic        s_awvalid = 0, s_awready, s_wvalid = 0, s_wready, s_bvalid, s_bready = 0;
    logic        s_arvalid = 0, s_arready, s_rvalid, s_rready = 0;
    logic [14:0] s_awaddr = '0, s_araddr = '0;
    logic [31:0] s_wdata = '0, s_rdata, m_wdata, m_rdata = '0;
    logic [3:0]  s_wstrb = '0, m_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        m_awvalid, m_awready = 0, m_wvalid, m_wready = 0, m_arvalid, m_arready = 0;
    logic        m_rvalid = 0, m_rready, cc_ls_enable;
    logic [9:0]  m_awaddr, m_araddr;

    fsic_ls_cfg_bridge dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .cc_ls_enable(cc_ls_enable)
    );

    always #5 axi_clk = ~axi_clk;

    int n_checks = 0;
    int n_pass = 0;

    // Downstream serdes model: 0 always ready, 1 random ready, 2 stuck.
    int          ds_mode = 0;
    logic [31:0] ds_mem [1024];
    logic [31:0] ref_mem [1024];
    logic [9:0]  ds_wa [$];
    logic [31:0] ds_wd [$];
    logic [3:0]  ds_ws [$];
    logic        ar_hs = 0, rd_pend = 0, r_hs = 0;
    logic [9:0]  ar_a = '0;

    always @(negedge axi_clk) begin
        if (!axi_reset_n) begin
            m_rvalid = 0; ar_hs = 0; rd_pend = 0; r_hs = 0;
        end else begin
            if (r_hs) begin m_rvalid = 0; r_hs = 0; end
            if (ar_hs) begin rd_pend = 1; ar_hs = 0; end
            m_awready = (ds_mode == 0) || (ds_mode == 1 && $urandom_range(1, 0) == 1);
            m_wready  = (ds_mode == 0) || (ds_mode == 1 && $urandom_range(1, 0) == 1);
            m_arready = (ds_mode == 0) || (ds_mode == 1 && $urandom_range(1, 0) == 1);
            if (m_awvalid && m_wvalid && m_awready && m_wready) begin
                for (int b = 0; b < 4; b++)
                    if (m_wstrb[b]) ds_mem[m_awaddr][8*b +: 8] = m_wdata[8*b +: 8];
                ds_wa.push_back(m_awaddr); ds_wd.push_back(m_wdata); ds_ws.push_back(m_wstrb);
            end
            if (m_arvalid && m_arready) begin ar_hs = 1; ar_a = m_araddr; end
            if (rd_pend && !m_rvalid && (ds_mode == 0 || $urandom_range(1, 0) == 1)) begin
                m_rvalid = 1; m_rdata = ds_mem[ar_a]; rd_pend = 0;
            end
            if (m_rvalid && m_rready) r_hs = 1;
        end
    end

    function automatic bit in_win(input logic [14:0] a);
        return (32'(a) >= BASE) && (32'(a) < BASE + SIZE);
    endfunction

    function automatic int woff(input logic [14:0] a);
        return (int'(a) - int'(BASE)) / 4;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Drives the requested upstream channels from a negedge; returns at the negedge after
    // the last handshake.
    task automatic drive(input bit do_aw, input logic [14:0] awa, input bit do_w,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input bit do_ar, input logic [14:0] ara);
        bit haw, hw, har;
        int n = 0;
        s_awaddr = awa; s_wdata = wd; s_wstrb = ws; s_araddr = ara;
        s_awvalid = do_aw; s_wvalid = do_w; s_arvalid = do_ar;
        while ((s_awvalid || s_wvalid || s_arvalid) && n < 200) begin
            haw = s_awvalid && s_awready;
            hw  = s_wvalid && s_wready;
            har = s_arvalid && s_arready;
            @(negedge axi_clk); n++;
            if (haw) s_awvalid = 0;
            if (hw)  s_wvalid = 0;
            if (har) s_arvalid = 0;
        end
        n_checks++;
        if (s_awvalid || s_wvalid || s_arvalid)
            $display("FAIL upstream_accept: valids %b still pending, required accepted",
                     {s_awvalid, s_wvalid, s_arvalid});
        else n_pass++;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    endtask

    int          ob_aw_at, ob_ar_at, ob_b_at, ob_r_at, ob_en;
    logic [9:0]  ob_awaddr;
    logic [31:0] ob_wdata, ob_rdata;
    logic [1:0]  ob_bresp, ob_rresp;
    bit          ob_r_unstable;

    // Records first-seen cycle (relative to the call) of each event over a window.
    task automatic observe(input int cycles);
        ob_aw_at = -1; ob_ar_at = -1; ob_b_at = -1; ob_r_at = -1; ob_en = 0;
        ob_r_unstable = 0;
        for (int i = 0; i < cycles; i++) begin
            if (m_awvalid && ob_aw_at < 0) begin
                ob_aw_at = i; ob_awaddr = m_awaddr; ob_wdata = m_wdata;
            end
            if (m_arvalid && ob_ar_at < 0) ob_ar_at = i;
            if (cc_ls_enable) ob_en++;
            if (s_bvalid && ob_b_at < 0) begin ob_b_at = i; ob_bresp = s_bresp; end
            if (s_rvalid) begin
                if (ob_r_at < 0) begin ob_r_at = i; ob_rdata = s_rdata; ob_rresp = s_rresp; end
                else if (s_rdata !== ob_rdata || s_rresp !== ob_rresp) ob_r_unstable = 1;
            end
            @(negedge axi_clk);
        end
    endtask

    task automatic wait_b(output logic [1:0] resp, output bit ok);
        int n = 0;
        s_bready = 1;
        while (!s_bvalid && n < 2000) begin @(negedge axi_clk); n++; end
        ok = s_bvalid; resp = s_bresp;
        @(negedge axi_clk); s_bready = 0;
    endtask

    task automatic wait_r(output logic [1:0] resp, output logic [31:0] data, output bit ok);
        int n = 0;
        s_rready = 1;
        while (!s_rvalid && n < 2000) begin @(negedge axi_clk); n++; end
        ok = s_rvalid; resp = s_rresp; data = s_rdata;
        @(negedge axi_clk); s_rready = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge axi_clk);
        n_checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, m_awvalid, m_wvalid,
             m_arvalid, m_rready, cc_ls_enable} !== 10'b0)
            $display("FAIL reset_ctrl: got %b required 0", {s_awready, s_wready, s_arready,
                     s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid, m_rready, cc_ls_enable});
        else n_pass++;
        n_checks++;
        if ({s_bresp, s_rresp, s_rdata} !== 36'h0)
            $display("FAIL reset_data: bresp %h rresp %h rdata %h required 0",
                     s_bresp, s_rresp, s_rdata);
        else n_pass++;
        axi_reset_n = 1;
        #1;
        n_checks++;
        if (s_awready !== 1'b0) $display("FAIL ready_before_edge: got %b required 0", s_awready);
        else n_pass++;
        @(negedge axi_clk);
        n_checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111)
            $display("FAIL ready_after_edge: got %b required 111",
                     {s_awready, s_wready, s_arready});
        else n_pass++;
    endtask

    task automatic test_write_hit();
        logic [1:0] r; bit ok;
        ds_mode = 0;
        drive(1, 15'h5000, 1, 32'h3, 4'hF, 0, '0);
        observe(8);
        ref_mem[0] = 32'h3;
        n_checks++;
        if (ob_aw_at !== 1 || ob_awaddr !== 10'd0 || ob_wdata !== 32'h3)
            $display("FAIL wr_issue: at %0d addr %h data %h required at 1 addr 0 data 3",
                     ob_aw_at, ob_awaddr, ob_wdata);
        else n_pass++;
        n_checks++;
        if (ob_en !== 1) $display("FAIL wr_enable_len: got %0d required 1", ob_en);
        else n_pass++;
        n_checks++;
        if (ob_b_at !== 2 || ob_bresp !== 2'b00)
            $display("FAIL wr_bvalid: at %0d resp %b required at 2 resp 00", ob_b_at, ob_bresp);
        else n_pass++;
        wait_b(r, ok);
    endtask

    task automatic test_split_aw_w();
        logic [1:0] r; bit ok;
        drive(1, 15'h5004, 0, '0, '0, 0, '0);
        observe(4);
        n_checks++;
        if (ob_aw_at !== -1 || ob_en !== 0)
            $display("FAIL split_early: aw at %0d en %0d required none", ob_aw_at, ob_en);
        else n_pass++;
        drive(0, '0, 1, 32'hA5, 4'hF, 0, '0);
        observe(4);
        ref_mem[1] = 32'hA5;
        n_checks++;
        if (ob_aw_at !== 1 || ob_awaddr !== 10'd1)
            $display("FAIL split_issue: at %0d addr %h required at 1 addr 1", ob_aw_at, ob_awaddr);
        else n_pass++;
        wait_b(r, ok);
        n_checks++;
        if (!ok || r !== 2'b00) $display("FAIL split_bresp: got %b required 00", r);
        else n_pass++;
    endtask

    task automatic test_read_hit();
        logic [1:0] r; logic [31:0] d; bit ok;
        drive(0, '0, 0, '0, '0, 1, 15'h5000);
        observe(14);
        n_checks++;
        if (ob_ar_at !== 1 || ob_r_at !== 3)
            $display("FAIL rd_timing: ar at %0d r at %0d required 1 and 3", ob_ar_at, ob_r_at);
        else n_pass++;
        n_checks++;
        if (ob_rdata !== 32'h3 || ob_rresp !== 2'b00 || ob_r_unstable)
            $display("FAIL rd_data: data %h resp %b unstable %0d required 3 00 0",
                     ob_rdata, ob_rresp, ob_r_unstable);
        else n_pass++;
        wait_r(r, d, ok);
    endtask

    task automatic test_miss();
        logic [1:0] r; logic [31:0] d; bit ok;
        drive(1, 15'h6000, 1, 32'hDEAD, 4'hF, 0, '0);
        observe(6);
        n_checks++;
        if (ob_b_at !== 1 || ob_bresp !== 2'b10 || ob_aw_at !== -1 || ob_en !== 0)
            $display("FAIL wr_miss: b at %0d resp %b aw at %0d en %0d required 1 10 -1 0",
                     ob_b_at, ob_bresp, ob_aw_at, ob_en);
        else n_pass++;
        wait_b(r, ok);
        drive(0, '0, 0, '0, '0, 1, 15'h4FFC);
        observe(6);
        n_checks++;
        if (ob_r_at !== 1 || ob_rdata !== 32'h0 || ob_rresp !== 2'b10 || ob_ar_at !== -1)
            $display("FAIL rd_miss: r at %0d data %h resp %b ar at %0d required 1 0 10 -1",
                     ob_r_at, ob_rdata, ob_rresp, ob_ar_at);
        else n_pass++;
        wait_r(r, d, ok);
    endtask

    task automatic test_arbitration();
        int order [$];
        logic [31:0] rdv [$];
        logic [31:0] d0, d1;
        int n;
        d0 = $urandom; d1 = $urandom;
        s_bready = 1; s_rready = 1;
        for (int round = 0; round < 2; round++) begin
            drive(1, 15'h5008 + 15'(4 * round), 1, round ? d1 : d0, 4'hF,
                  1, 15'h5008 + 15'(4 * round));
            ref_mem[2 + round] = round ? d1 : d0;
            n = 0;
            while (order.size() < 2 * (round + 1) && n < 100) begin
                if (s_bvalid) order.push_back(0);
                if (s_rvalid) begin order.push_back(1); rdv.push_back(s_rdata); end
                @(negedge axi_clk); n++;
            end
        end
        s_bready = 0; s_rready = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= order.size() || order[i] !== (i % 2))
                $display("FAIL arb_order[%0d]: got %0d required %0d", i,
                         (i < order.size()) ? order[i] : -1, i % 2);
            else n_pass++;
        end
        n_checks++;
        if (rdv.size() != 2 || rdv[0] !== d0 || rdv[1] !== d1)
            $display("FAIL arb_rdata: got %0d reads required %h %h", rdv.size(), d0, d1);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [14:0] a; logic [31:0] wd, d; logic [3:0] ws; logic [1:0] r; bit ok, hit;
        int skew;
        ds_mode = 1;
        ds_wa.delete(); ds_wd.delete(); ds_ws.delete();
        for (int t = 0; t < 40; t++) begin
            a = 15'(32'h4F00 + $urandom_range(32'h1200, 0));
            hit = in_win(a);
            if ($urandom_range(1, 0) == 1) begin
                wd = $urandom; ws = 4'($urandom); skew = $urandom_range(2, 0);
                if (skew == 0) drive(1, a, 1, wd, ws, 0, '0);
                else if (skew == 1) begin drive(1, a, 0, '0, '0, 0, '0); drive(0, '0, 1, wd, ws, 0, '0); end
                else begin drive(0, '0, 1, wd, ws, 0, '0); drive(1, a, 0, '0, '0, 0, '0); end
                wait_b(r, ok);
                n_checks++;
                if (!ok || r !== (hit ? 2'b00 : 2'b10))
                    $display("FAIL rnd_bresp a=%h: got %b ok %0d required %b", a, r, ok,
                             hit ? 2'b00 : 2'b10);
                else n_pass++;
                n_checks++;
                if (hit) begin
                    if (ds_wa.size() != 1 || ds_wa[0] !== 10'(woff(a)) || ds_wd[0] !== wd ||
                        ds_ws[0] !== ws)
                        $display("FAIL rnd_dswrite a=%h: got %0d writes required addr %h data %h",
                                 a, ds_wa.size(), 10'(woff(a)), wd);
                    else n_pass++;
                    ref_mem[woff(a)] = merge(ref_mem[woff(a)], wd, ws);
                end else begin
                    if (ds_wa.size() != 0)
                        $display("FAIL rnd_nowrite a=%h: got %0d writes required 0", a,
                                 ds_wa.size());
                    else n_pass++;
                end
                ds_wa.delete(); ds_wd.delete(); ds_ws.delete();
            end else begin
                drive(0, '0, 0, '0, '0, 1, a);
                wait_r(r, d, ok);
                n_checks++;
                if (!ok || r !== (hit ? 2'b00 : 2'b10) || d !== (hit ? ref_mem[woff(a)] : 32'h0))
                    $display("FAIL rnd_read a=%h: got %h/%b required %h/%b", a, d, r,
                             hit ? ref_mem[woff(a)] : 32'h0, hit ? 2'b00 : 2'b10);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stuck_and_reset();
        logic [1:0] r; logic [31:0] d; bit ok;
        ds_mode = 2;
        drive(0, '0, 0, '0, '0, 1, 15'h5010);
        observe(300);
`ifdef LS_CFG_TIMEOUT_EN
        n_checks++;
        if (ob_r_at !== 257 || ob_rresp !== 2'b10 || ob_rdata !== 32'h0 || m_arvalid !== 1'b0)
            $display("FAIL timeout: r at %0d resp %b data %h arvalid %b required 257 10 0 0",
                     ob_r_at, ob_rresp, ob_rdata, m_arvalid);
        else n_pass++;
        wait_r(r, d, ok);
        drive(0, '0, 0, '0, '0, 1, 15'h5010);
`else
        n_checks++;
        if (ob_r_at !== -1 || m_arvalid !== 1'b1 || cc_ls_enable !== 1'b1)
            $display("FAIL stuck_wait: r at %0d arvalid %b en %b required -1 1 1",
                     ob_r_at, m_arvalid, cc_ls_enable);
        else n_pass++;
`endif
        repeat (20) @(negedge axi_clk);
        #2 axi_reset_n = 0;
        #1;
        n_checks++;
        if ({m_arvalid, cc_ls_enable, s_rvalid, s_bvalid, m_rready, s_arready} !== 6'b0)
            $display("FAIL async_reset: got %b required 0",
                     {m_arvalid, cc_ls_enable, s_rvalid, s_bvalid, m_rready, s_arready});
        else n_pass++;
        @(negedge axi_clk);
        axi_reset_n = 1;
        ds_mode = 0;
        observe(6);
        n_checks++;
        if (ob_r_at !== -1 || ob_ar_at !== -1 || s_arready !== 1'b1)
            $display("FAIL post_reset: r at %0d ar at %0d arready %b required -1 -1 1",
                     ob_r_at, ob_ar_at, s_arready);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin ds_mem[i] = '0; ref_mem[i] = '0; end
        test_reset();
        test_write_hit();
        test_split_aw_w();
        test_read_hit();
        test_miss();
        test_arbitration();
        test_random();
        test_stuck_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
